vpu_alu_minmax_tree: RTL and testbench
======================================

// Module: vpu_alu_minmax_tree
// PURPOSE
//  Parametrised successor to the VPU ALU max unit: N-source min/max reduction, signed/unsigned,
//  with per-source valid masking and arg-index output. Pipelined compare tree, one register per level.
//  Sits between the VPU source ports and the VPU destination port, started by the VPU controller.
//  Completion is timed by a delay counter, as for the other ALU units.
// PARAMETERS
//  OPCODE_WIDTH   32  element width in bits
//  SRC_CNT        4   number of source operands (>=2; need not be a power of 2)
//  MAX_DELAY_LG2  4   width of delay_i / delay counter
//  LAT            $clog2(SRC_CNT)  derived: tree depth = result latency in cycles
// PORTS
//  clk        in   1                         clock (single clock domain)
//  rst        in   1                         synchronous, active-high reset
//  delay_i    in   MAX_DELAY_LG2             done delay from REQ_IF, sampled on start_i
//  mode_i     in   2                         minmax_op_t, sampled on start_i
//  op_i       in   SRC_CNT*OPCODE_WIDTH      packed operands; lane k = op_i[k*W +: W]
//  op_valid   in   SRC_CNT                   lane valid mask, sampled on start_i
//  start_i    in   1                         1-cycle start from VPU controller
//  result_o   out  OPCODE_WIDTH              selected element
//  idx_o      out  $clog2(SRC_CNT)           lane index of result_o
//  empty_o    out  1                         no lane was valid
//  valid_o    out  1                         result_o/idx_o/empty_o hold a completed result
//  done_o     out  1                         delay elapsed and result valid (level)
// BEHAVIOUR
//  - Reset: every pipeline register, result_o, idx_o, empty_o, valid_o, done_o and the counter = 0.
//  - mode_i: 00 MAX_U, 01 MAX_S, 10 MIN_U, 11 MIN_S; the _S modes use two's-complement compare.
//  - Invalid lanes never win. Tie (equal values): the lower lane index wins, in all modes.
//  - All lanes invalid: result_o = 0, idx_o = 0, empty_o = 1.
//  - Pipeline: stage 0 captures the masked operands on start_i (cycle T). Each tree level is one register.
//    result_o/idx_o/empty_o update and valid_o rises at T+LAT (T+1 when SRC_CNT = 2).
//    They then hold until the next start_i completes.
//  - Odd lane count at any level: the unpaired entry is forwarded with its valid/idx, delayed one stage.
//  - Delay counter: loaded with delay_i on start_i and decrements to 0, then saturates.
//    done_o = valid_o && (counter == 0), so done_o rises at T + max(delay_i, LAT).
//    done_o stays high until the next start_i.
//  - start_i clears valid_o and done_o on the next edge (T+1), including while a start is in flight.
//    On a start while busy, all in-flight stages are flushed (per-stage valid cleared).
//    Only the newest start produces a result; an aborted start never raises valid_o.
//  - Back-to-back start_i on consecutive cycles: each aborts the previous; only the last completes.
//  - rst asserted mid-operation: the in-flight op is discarded and outputs return to reset values next edge.
//  - No backpressure: the destination port must consume the result while done_o is high.
// STRUCTURE
//  - VPU_PKG gains: typedef enum logic [1:0] minmax_op_t {MAX_U, MAX_S, MIN_U, MIN_S};
//    also function minmax_lat(int n) returning $clog2(n).
//  - Sub-module vpu_minmax_cmp: combinational 2-input compare-select.
//    Inputs are {valid, idx, value} x2 plus mode; it applies the tie and invalid rules.
//    Instantiated SRC_CNT-1 times via generate, with the tree registers in this module.
//  - Delay counter reuses the existing VPU timing counter (active-high sync reset variant).
// TESTING
//  1. W=32, N=4, MAX_U, ops {5,9,3,9}, valid 1111, delay 0: at T+2 result 9, idx 1, valid_o=done_o=1.
//  2. MIN_S vs MIN_U on ops {0xFFFFFFFF,1,2,3}: MIN_S gives result 0xFFFFFFFF, idx 0.
//     MIN_U gives result 1, idx 1.
//  3. Masking: MAX_U, ops {100,7,8,6}, valid 1110: result 8, idx 2.
//     Then valid 0000: result 0, idx 0, empty_o=1.
//  4. Delay: delay_i=6, N=4: valid_o at T+2, done_o rises exactly at T+6 and holds until the next start.
//  5. Abort: start A at T and start B at T+1 give only B's result at T+3.
//     valid_o is never set for A. Also rst at T+1 leaves all outputs 0 through T+5.
//  6. N=5 (odd), MAX_S, ops {-3,-1,-7,-2,-1}: result -1, idx 1 (tie to lowest index), at T+3.

Source files
------------

// File: rtl/vpu_alu_minmax_tree_pkg.sv
// Shared types and helpers for the VPU min/max reduction unit.
package vpu_alu_minmax_tree_pkg;

    typedef enum logic [1:0] {
        MAX_U = 2'b00,
        MAX_S = 2'b01,
        MIN_U = 2'b10,
        MIN_S = 2'b11
    } minmax_op_t;

    function automatic int minmax_lat(int n);
        return $clog2(n);
    endfunction

    // Entries left at tree level lvl when an odd entry is forwarded unpaired.
    function automatic int level_count(int n, int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/vpu_minmax_cmp.sv
// Two-input compare-select: invalid entries never win, ties keep the lower-index input a.
module vpu_minmax_cmp
    import vpu_alu_minmax_tree_pkg::*;
#(
    parameter int W     = 32,
    parameter int IDX_W = 2
) (
    input  logic [1:0]       mode,
    input  logic             a_v,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [W-1:0]     a_val,
    input  logic             b_v,
    input  logic [IDX_W-1:0] b_idx,
    input  logic [W-1:0]     b_val,
    output logic             out_v,
    output logic [IDX_W-1:0] out_idx,
    output logic [W-1:0]     out_val
);

    minmax_op_t op;
    logic       b_better;
    logic       pick_b;

    assign op = minmax_op_t'(mode);

    always_comb begin
        b_better = 1'b0;
        case (op)
            MAX_U:   b_better = b_val > a_val;
            MAX_S:   b_better = $signed(b_val) > $signed(a_val);
            MIN_U:   b_better = b_val < a_val;
            MIN_S:   b_better = $signed(b_val) < $signed(a_val);
            default: b_better = 1'b0;
        endcase
    end

    assign pick_b  = b_v && (!a_v || b_better);
    assign out_v   = a_v || b_v;
    assign out_idx = pick_b ? b_idx : a_idx;
    assign out_val = pick_b ? b_val : a_val;

endmodule

// File: rtl/vpu_alu_minmax_tree.sv
// N-source min/max reduction with arg-index, pipelined as one register per compare-tree level.
module vpu_alu_minmax_tree
    import vpu_alu_minmax_tree_pkg::*;
#(
    parameter int OPCODE_WIDTH  = 32,
    parameter int SRC_CNT       = 4,
    parameter int MAX_DELAY_LG2 = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MAX_DELAY_LG2-1:0]          delay_i,
    input  logic [1:0]                        mode_i,
    input  logic [SRC_CNT*OPCODE_WIDTH-1:0]   op_i,
    input  logic [SRC_CNT-1:0]                op_valid,
    input  logic                              start_i,
    output logic [OPCODE_WIDTH-1:0]           result_o,
    output logic [$clog2(SRC_CNT)-1:0]        idx_o,
    output logic                              empty_o,
    output logic                              valid_o,
    output logic                              done_o
);

    localparam int W     = OPCODE_WIDTH;
    localparam int LAT   = minmax_lat(SRC_CNT);
    localparam int IDX_W = $clog2(SRC_CNT);

    logic [1:0]               mode_q;
    logic [MAX_DELAY_LG2-1:0] delay_cnt;
    logic                     fin_v;
    logic [IDX_W-1:0]         fin_idx;
    logic [W-1:0]             fin_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
        end else if (start_i) begin
            mode_q <= mode_i;
        end
    end

    // Level 0 holds the masked operands; levels 1..LAT-1 are tree registers; level LAT feeds the outputs.
    for (genvar l = 0; l <= LAT; l++) begin : g_lvl
        localparam int CNT  = level_count(SRC_CNT, l);
        localparam int PCNT = (l == 0) ? SRC_CNT : level_count(SRC_CNT, l - 1);

        for (genvar e = 0; e < CNT; e++) begin : g_ent
            logic             c_v;
            logic [IDX_W-1:0] c_idx;
            logic [W-1:0]     c_val;

            if (l == 0) begin : g_src
                assign c_v   = op_valid[e];
                assign c_idx = IDX_W'(e);
                assign c_val = op_valid[e] ? op_i[e*W +: W] : '0;
            end else if (2 * e + 1 < PCNT) begin : g_pair
                vpu_minmax_cmp #(
                    .W     (W),
                    .IDX_W (IDX_W)
                ) u_cmp (
                    .mode    (mode_q),
                    .a_v     (g_lvl[l-1].g_ent[2*e].g_reg.r_v),
                    .a_idx   (g_lvl[l-1].g_ent[2*e].g_reg.r_idx),
                    .a_val   (g_lvl[l-1].g_ent[2*e].g_reg.r_val),
                    .b_v     (g_lvl[l-1].g_ent[2*e+1].g_reg.r_v),
                    .b_idx   (g_lvl[l-1].g_ent[2*e+1].g_reg.r_idx),
                    .b_val   (g_lvl[l-1].g_ent[2*e+1].g_reg.r_val),
                    .out_v   (c_v),
                    .out_idx (c_idx),
                    .out_val (c_val)
                );
            end else begin : g_pass
                assign c_v   = g_lvl[l-1].g_ent[2*e].g_reg.r_v;
                assign c_idx = g_lvl[l-1].g_ent[2*e].g_reg.r_idx;
                assign c_val = g_lvl[l-1].g_ent[2*e].g_reg.r_val;
            end

            if (l < LAT) begin : g_reg
                logic             r_v;
                logic [IDX_W-1:0] r_idx;
                logic [W-1:0]     r_val;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_v   <= 1'b0;
                        r_idx <= '0;
                        r_val <= '0;
                    end else if (start_i || (l != 0)) begin
                        r_v   <= c_v;
                        r_idx <= c_idx;
                        r_val <= c_val;
                    end
                end
            end
        end

        // Stage occupancy: a new start flushes everything behind stage 0.
        if (l < LAT) begin : g_stage
            logic sv;
            if (l == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sv <= 1'b0;
                    end else begin
                        sv <= start_i;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst || start_i) begin
                        sv <= 1'b0;
                    end else begin
                        sv <= g_lvl[l-1].g_stage.sv;
                    end
                end
            end
        end
    end

    assign fin_v   = g_lvl[LAT].g_ent[0].c_v;
    assign fin_idx = g_lvl[LAT].g_ent[0].c_idx;
    assign fin_val = g_lvl[LAT].g_ent[0].c_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= '0;
            idx_o    <= '0;
            empty_o  <= 1'b0;
            valid_o  <= 1'b0;
        end else if (start_i) begin
            valid_o  <= 1'b0;
        end else if (g_lvl[LAT-1].g_stage.sv) begin
            result_o <= fin_v ? fin_val : '0;
            idx_o    <= fin_v ? fin_idx : '0;
            empty_o  <= !fin_v;
            valid_o  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_cnt <= '0;
        end else if (start_i) begin
            delay_cnt <= delay_i;
        end else if (delay_cnt != '0) begin
            delay_cnt <= delay_cnt - 1'b1;
        end
    end

    assign done_o = valid_o && (delay_cnt == '0);

endmodule

// File: tb/tb_vpu_alu_minmax_tree.sv
// Directed bench for the min/max tree: 4-lane and 5-lane instances checked against a queued linear-scan model.
module tb_vpu_alu_minmax_tree;
    import vpu_alu_minmax_tree_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]     delay4;
    logic [1:0]     mode4;
    logic [4*W-1:0] op4;
    logic [3:0]     valid4;
    logic           start4;
    logic [W-1:0]   result4;
    logic [1:0]     idx4;
    logic           empty4, vout4, done4;

    logic [3:0]     delay5;
    logic [1:0]     mode5;
    logic [5*W-1:0] op5;
    logic [4:0]     valid5;
    logic           start5;
    logic [W-1:0]   result5;
    logic [2:0]     idx5;
    logic           empty5, vout5, done5;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  idx;
        logic        empty;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stim_ops [5];
    logic [4:0]  stim_valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    vpu_alu_minmax_tree #(.OPCODE_WIDTH(W), .SRC_CNT(4), .MAX_DELAY_LG2(4)) dut4 (
        .clk(clk), .rst(rst), .delay_i(delay4), .mode_i(mode4), .op_i(op4),
        .op_valid(valid4), .start_i(start4), .result_o(result4), .idx_o(idx4),
        .empty_o(empty4), .valid_o(vout4), .done_o(done4)
    );

    vpu_alu_minmax_tree #(.OPCODE_WIDTH(W), .SRC_CNT(5), .MAX_DELAY_LG2(4)) dut5 (
        .clk(clk), .rst(rst), .delay_i(delay5), .mode_i(mode5), .op_i(op5),
        .op_valid(valid5), .start_i(start5), .result_o(result5), .idx_o(idx5),
        .empty_o(empty5), .valid_o(vout5), .done_o(done5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: linear scan, strictly-better replaces, so ties stay on the lowest lane.
    function automatic exp_t model(input logic [1:0] mode, input int n);
        exp_t e;
        int   best;
        logic better;
        best = -1;
        for (int i = 0; i < n; i++) begin
            if (stim_valid[i]) begin
                if (best < 0) begin
                    best = i;
                end else begin
                    case (mode)
                        2'b00:   better = stim_ops[i] > stim_ops[best];
                        2'b01:   better = $signed(stim_ops[i]) > $signed(stim_ops[best]);
                        2'b10:   better = stim_ops[i] < stim_ops[best];
                        default: better = $signed(stim_ops[i]) < $signed(stim_ops[best]);
                    endcase
                    if (better) best = i;
                end
            end
        end
        e.res   = (best < 0) ? 32'd0 : stim_ops[best];
        e.idx   = (best < 0) ? 3'd0 : 3'(best);
        e.empty = (best < 0);
        return e;
    endfunction

    // Called on a negedge; the start is sampled by the following posedge.
    task automatic apply_stimulus(input bit on5, input logic [1:0] mode, input logic [3:0] delay);
        exp_q.delete();
        exp_q.push_back(model(mode, on5 ? 5 : 4));
        if (on5) begin
            mode5  = mode;
            delay5 = delay;
            valid5 = stim_valid;
            op5    = {stim_ops[4], stim_ops[3], stim_ops[2], stim_ops[1], stim_ops[0]};
            start5 = 1'b1;
        end else begin
            mode4  = mode;
            delay4 = delay;
            valid4 = stim_valid[3:0];
            op4    = {stim_ops[3], stim_ops[2], stim_ops[1], stim_ops[0]};
            start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic check_output(input bit on5, input int exp_lat, input string tag);
        exp_t e;
        int   k;
        bit   seen;
        seen = 1'b0;
        k    = 0;
        check({tag, "_valid_cleared"}, 32'(on5 ? vout5 : vout4), 32'd0);
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (on5 ? vout5 : vout4) begin
                seen = 1'b1;
                k    = c;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        e = exp_q.pop_front();
        if (seen) begin
            check({tag, "_result"}, on5 ? result5 : result4, e.res);
            check({tag, "_idx"}, on5 ? 32'(idx5) : 32'(idx4), 32'(e.idx));
            check({tag, "_empty"}, 32'(on5 ? empty5 : empty4), 32'(e.empty));
        end
    endtask

    initial begin
        rst = 1'b1;
        {delay4, mode4, op4, valid4, start4} = '0;
        {delay5, mode5, op5, valid5, start5} = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result4, 32'd0);
        check("rst_idx", 32'(idx4), 32'd0);
        check("rst_empty", 32'(empty4), 32'd0);
        check("rst_valid", 32'(vout4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_valid_n5", 32'(vout5), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        stim_ops = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd0};
        stim_valid = 5'b01111;
        apply_stimulus(1'b0, MAX_U, 4'd0);
        check_output(1'b0, 2, "max_u");
        check("max_u_done", 32'(done4), 32'd1);

        stim_ops = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd0};
        apply_stimulus(1'b0, MIN_S, 4'd0);
        check_output(1'b0, 2, "min_s");
        apply_stimulus(1'b0, MIN_U, 4'd0);
        check_output(1'b0, 2, "min_u");

        stim_ops = '{32'd100, 32'd7, 32'd8, 32'd6, 32'd0};
        stim_valid = 5'b01110;
        apply_stimulus(1'b0, MAX_U, 4'd0);
        check_output(1'b0, 2, "mask");
        stim_valid = 5'b00000;
        apply_stimulus(1'b0, MAX_U, 4'd0);
        check_output(1'b0, 2, "all_invalid");

        stim_ops = '{32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd3, 32'd0};
        stim_valid = 5'b01111;
        apply_stimulus(1'b0, MAX_S, 4'd0);
        check_output(1'b0, 2, "max_s");
        stim_ops = '{32'd4, 32'd2, 32'd9, 32'd2, 32'd0};
        apply_stimulus(1'b0, MIN_U, 4'd0);
        check_output(1'b0, 2, "min_u_tie");
        stim_valid = 5'b01000;
        apply_stimulus(1'b0, MIN_S, 4'd0);
        check_output(1'b0, 2, "lane3_only");

        stim_ops = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        stim_valid = 5'b01111;
        apply_stimulus(1'b0, MAX_U, 4'd6);
        check_output(1'b0, 2, "delay6");
        check("delay6_done_t2", 32'(done4), 32'd0);
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("delay6_done_t%0d", c), 32'(done4), 32'(c >= 6));
        end
        check("delay6_valid_hold", 32'(vout4), 32'd1);

        stim_ops = '{32'd50, 32'd60, 32'd70, 32'd80, 32'd0};
        apply_stimulus(1'b0, MAX_U, 4'd0);
        check("abort_done_cleared", 32'(done4), 32'd0);
        apply_stimulus(1'b0, MIN_U, 4'd0);
        check_output(1'b0, 2, "abort_b");

        stim_ops = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd0};
        apply_stimulus(1'b0, MAX_U, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("midrst_result_t%0d", c), result4, 32'd0);
            check($sformatf("midrst_valid_t%0d", c), 32'(vout4), 32'd0);
            check($sformatf("midrst_done_t%0d", c), 32'(done4), 32'd0);
        end

        stim_ops = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        stim_valid = 5'b11111;
        apply_stimulus(1'b1, MAX_S, 4'd0);
        check_output(1'b1, 3, "n5_max_s");
        check("n5_done", 32'(done5), 32'd1);
        stim_valid = 5'b10000;
        apply_stimulus(1'b1, MIN_U, 4'd0);
        check_output(1'b1, 3, "n5_lane4_only");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
